// File: rtl/cond_pkg.sv
// Shared condition-code definitions: mnemonic encoding, NZCV bit positions and
// the condition evaluator used by the flag controller.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v, r;
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      case (cond_e'(cond))
         EQ:      r = z;
         NE:      r = !z;
         CS:      r = c;
         CC:      r = !c;
         MI:      r = n;
         PL:      r = !n;
         VS:      r = v;
         VC:      r = !v;
         HI:      r = !z && c;
         LS:      r = z || !c;
         GE:      r = (n == v);
         LT:      r = (n != v);
         GT:      r = !z && (n == v);
         LE:      r = z || (n != v);
         AL:      r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO for saved flag words with push, pop and swap (push+pop) and a sticky
// overflow/underflow flag. Entries are left unreset; only the count is.
module flag_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         pop_ok,
   output logic         full,
   output logic         empty,
   output logic         err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     mem [2**IDX_W];
   logic [CNT_W-1:0] top_ptr, wr_ptr;
   logic             do_push, do_pop, do_swap, err_set;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign top_ptr = cnt_q - CNT_W'(1);

   // A simultaneous push+pop on an empty stack is an underflow, not a swap.
   assign do_swap = push && pop && !empty;
   assign do_push = push && !pop && !full;
   assign do_pop  = pop && !push && !empty;
   assign err_set = (push && !pop && full) || (pop && empty);
   assign pop_ok  = do_pop || do_swap;
   assign wr_ptr  = do_swap ? top_ptr : cnt_q;
   assign top     = mem[top_ptr[IDX_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err   <= 1'b0;
      end else begin
         if (do_push)
            cnt_q <= cnt_q + CNT_W'(1);
         else if (do_pop)
            cnt_q <= cnt_q - CNT_W'(1);
         if (err_set)
            err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push || do_swap)
         mem[wr_ptr[IDX_W-1:0]] <= din;
   end

endmodule

// File: rtl/cond_flag_ctrl.sv
// Banked NZCV flag registers with condition evaluation, predicated flag
// commit, and a save/restore stack for exception entry and return.
module cond_flag_ctrl
   import cond_pkg::*;
#(
   parameter int NUM_CTX     = 2,
   parameter int STACK_DEPTH = 4,
   parameter int CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic [3:0]       cond,
   input  logic [CTX_W-1:0] ctx_sel,
   input  logic [3:0]       alu_flags,
   input  logic [1:0]       flag_write,
   input  logic             push,
   input  logic             pop,
   output logic             cond_ex,
   output logic [3:0]       flags_out,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   logic [NUM_CTX-1:0][3:0] bank_q;
   logic [3:0]              sel_flags, wr_flags, bank_d, stk_top;
   logic                    ctx_ok, stk_pop_ok;

   assign ctx_ok = ({1'b0, ctx_sel} < (CTX_W + 1)'(NUM_CTX));

   // Mux by comparison so an out-of-range select reads as zero flags.
   always_comb begin
      sel_flags = '0;
      for (int i = 0; i < NUM_CTX; i++)
         if (ctx_sel == CTX_W'(i))
            sel_flags = bank_q[i];
   end

   assign cond_ex   = ctx_ok && cond_eval(cond, sel_flags);
   assign flags_out = sel_flags;

   always_comb begin
      wr_flags = sel_flags;
      if (instr_valid && cond_ex) begin
         if (flag_write[1])
            wr_flags[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
         if (flag_write[0])
            wr_flags[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
      end
   end

   // Restore from the stack wins over a same-cycle ALU update.
   assign bank_d = stk_pop_ok ? stk_top : wr_flags;

   flag_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (4)
   ) u_stack (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push && ctx_ok),
      .pop    (pop && ctx_ok),
      .din    (wr_flags),
      .top    (stk_top),
      .pop_ok (stk_pop_ok),
      .full   (stack_full),
      .empty  (stack_empty),
      .err    (stack_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bank_q <= '0;
      else
         for (int i = 0; i < NUM_CTX; i++)
            if (ctx_ok && ctx_sel == CTX_W'(i))
               bank_q[i] <= bank_d;
   end

endmodule

// File: tb/tb_cond_flag_ctrl.sv
// Directed and random stimulus for cond_flag_ctrl, checked against a
// queue-based behavioural model of the flag banks and save stack.
module tb_cond_flag_ctrl;

   localparam int NCTX  = 3;
   localparam int DEPTH = 4;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic [3:0]    cond = 4'd0;
   logic [CW-1:0] ctx_sel = '0;
   logic [3:0]    alu_flags = 4'd0;
   logic [1:0]    flag_write = 2'd0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          cond_ex;
   logic [3:0]    flags_out;
   logic          stack_full, stack_empty, stack_err;

   int checks = 0;
   int errors = 0;

   bit [3:0] m_bank [NCTX];
   bit [3:0] m_stk [$];
   bit       m_err;

   always #5 clk = ~clk;

   cond_flag_ctrl #(.NUM_CTX(NCTX), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .cond(cond),
      .ctx_sel(ctx_sel), .alu_flags(alu_flags), .flag_write(flag_write),
      .push(push), .pop(pop), .cond_ex(cond_ex), .flags_out(flags_out),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ARM condition table: pairs share a base test, odd codes invert it.
   function automatic bit ref_ex(input int c, input bit [3:0] f);
      bit n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c >> 1)
         0: base = z;
         1: base = cf;
         2: base = n;
         3: base = v;
         4: base = cf && !z;
         5: base = (n == v);
         6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 15) return 1'b0;
      return (c % 2 == 1) ? !base : base;
   endfunction

   function automatic bit [3:0] ref_sel(input int ctx);
      return (ctx < NCTX) ? m_bank[ctx] : 4'b0000;
   endfunction

   task automatic model_clock(input bit v, input int c, input int ctx, input bit [3:0] af,
                              input bit [1:0] fw, input bit pu, input bit po);
      bit [3:0] f, nf;
      f  = ref_sel(ctx);
      nf = f;
      if (ctx < NCTX) begin
         if (v && ref_ex(c, f)) begin
            if (fw[1]) nf[3:2] = af[3:2];
            if (fw[0]) nf[1:0] = af[1:0];
         end
         if (pu && po) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else begin
               bit [3:0] t;
               t = m_stk.pop_back();
               m_stk.push_back(nf);
               nf = t;
            end
         end else if (pu) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else m_stk.push_back(nf);
         end else if (po) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else nf = m_stk.pop_back();
         end
         m_bank[ctx] = nf;
      end
   endtask

   // Drive one cycle: check combinational outputs, clock, then check state.
   task automatic step(input bit v, input int c, input int ctx, input bit [3:0] af,
                       input bit [1:0] fw, input bit pu, input bit po);
      instr_valid = v; cond = 4'(c); ctx_sel = CW'(ctx);
      alu_flags = af; flag_write = fw; push = pu; pop = po;
      #1;
      chk("cond_ex", 32'(cond_ex), 32'(ref_ex(c, ref_sel(ctx)) && ctx < NCTX));
      chk("flags_out", 32'(flags_out), 32'(ref_sel(ctx)));
      @(posedge clk);
      model_clock(v, c, ctx, af, fw, pu, po);
      @(negedge clk);
      chk("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
      chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("stack_err", 32'(stack_err), 32'(m_err));
   endtask

   task automatic peek(input int ctx, input bit [3:0] exp, input string tag);
      ctx_sel = CW'(ctx); instr_valid = 1'b0; push = 1'b0; pop = 1'b0;
      #1;
      chk(tag, 32'(flags_out), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < NCTX; i++) m_bank[i] = 4'b0;
      m_err = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      chk("rst_flags", 32'(flags_out), 32'h0);
      chk("rst_empty", 32'(stack_empty), 32'h1);
      chk("rst_full", 32'(stack_full), 32'h0);
      chk("rst_err", 32'(stack_err), 32'h0);
      cond = 4'b1110; #1;
      chk("rst_al", 32'(cond_ex), 32'h1);
      cond = 4'b0000; #1;
      chk("rst_eq", 32'(cond_ex), 32'h0);

      step(1, 14, 0, 4'b0100, 2'b11, 0, 0);
      peek(0, 4'b0100, "wr_ctx0");
      peek(1, 4'b0000, "ctx1_untouched");
      step(0, 0, 0, 4'b0000, 2'b00, 0, 0);
      step(1, 1, 0, 4'b1010, 2'b11, 0, 0);
      peek(0, 4'b0100, "suppressed");
      step(1, 14, 0, 4'b1111, 2'b01, 0, 0);
      peek(0, 4'b0111, "partial");

      step(1, 14, 0, 4'b0100, 2'b11, 1, 0);
      step(1, 14, 0, 4'b0010, 2'b11, 1, 0);
      step(1, 14, 0, 4'b1111, 2'b11, 0, 1);
      peek(0, 4'b0010, "pop1");
      step(0, 14, 0, 4'b0000, 2'b00, 0, 1);
      peek(0, 4'b0100, "pop2");
      step(0, 14, 0, 4'b0000, 2'b00, 0, 1);
      chk("underflow_err", 32'(stack_err), 32'h1);

      step(1, 14, 0, 4'b0001, 2'b11, 1, 0);
      step(1, 14, 1, 4'b1000, 2'b11, 1, 0);
      step(1, 14, 2, 4'b1100, 2'b11, 1, 0);
      step(1, 14, 0, 4'b0110, 2'b11, 1, 0);
      chk("fill_full", 32'(stack_full), 32'h1);
      step(1, 14, 1, 4'b0011, 2'b11, 1, 0);
      step(1, 14, 0, 4'b1001, 2'b11, 0, 0);
      step(0, 14, 0, 4'b0000, 2'b00, 1, 1);
      peek(0, 4'b0110, "swap_bank");
      chk("swap_full", 32'(stack_full), 32'h1);
      step(0, 14, 3, 4'b1111, 2'b11, 1, 1);
      step(0, 14, 2, 4'b0000, 2'b00, 0, 1);
      peek(2, 4'b1001, "swap_top");

      // Async reset between edges with count 3 and non-zero banks.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_flags", 32'(flags_out), 32'h0);
      chk("arst_empty", 32'(stack_empty), 32'h1);
      chk("arst_err", 32'(stack_err), 32'h0);
      for (int i = 0; i < NCTX; i++) m_bank[i] = 4'b0;
      m_stk.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 400; k++)
         step(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              4'($urandom), 2'($urandom), ($urandom % 3) == 0, ($urandom % 4) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
